// File: rtl/camellia_pkg.sv
// camellia_pkg: step encodings, subkey bank indices and sequencer state type
// shared by the Camellia-128 round controller and its subkey-index ROM.
package camellia_pkg;

    localparam logic [1:0] STEP_WIN  = 2'd0;
    localparam logic [1:0] STEP_F    = 2'd1;
    localparam logic [1:0] STEP_FL   = 2'd2;
    localparam logic [1:0] STEP_WOUT = 2'd3;

    localparam logic [4:0] KSEL_KW1 = 5'd0;
    localparam logic [4:0] KSEL_KW2 = 5'd1;
    localparam logic [4:0] KSEL_K1  = 5'd2;
    localparam logic [4:0] KSEL_KL1 = 5'd8;
    localparam logic [4:0] KSEL_KL3 = 5'd16;
    localparam logic [4:0] KSEL_K13 = 5'd18;
    localparam logic [4:0] KSEL_KW3 = 5'd24;
    localparam logic [4:0] KSEL_KW4 = 5'd25;

    typedef enum logic [2:0] {
        ST_IDLE, ST_KEYGEN, ST_READY, ST_PRE, ST_RND, ST_FL, ST_POST, ST_OUT
    } state_t;

endpackage

// File: rtl/camellia_ksel_rom.sv
// camellia_ksel_rom: maps (step, round counter, direction, FL position) to a
// subkey bank index; decrypt indices mirror the encrypt ones around the bank centre.
module camellia_ksel_rom
    import camellia_pkg::*;
(
    input  logic [1:0] i_step,
    input  logic [4:0] i_rc,
    input  logic       i_dec,
    input  logic       i_fl_second,
    output logic [4:0] o_ksel
);

    logic [4:0] w_rnd;
    logic [4:0] w_enc;

    // k1..k6, k7..k12, k13..k18 are separated by the two-entry kL pairs
    assign w_rnd = i_rc + (i_rc >= 5'd12 ? KSEL_K13 - 5'd12 :
                           i_rc >= 5'd6  ? KSEL_KL3 - 5'd12 : KSEL_K1);

    assign w_enc = i_step == STEP_WIN ? KSEL_KW1 :
                   i_step == STEP_F   ? w_rnd :
                   i_step == STEP_FL  ? (i_fl_second ? KSEL_KL3 : KSEL_KL1) :
                   KSEL_KW3;

    // round keys reverse over 2..23, pair steps over pair bases 0..24
    assign o_ksel = !i_dec           ? w_enc :
                    i_step == STEP_F ? KSEL_KW4 - w_enc :
                    KSEL_KW3 - w_enc;

endmodule

// File: rtl/camellia_round_ctrl.sv
// camellia_round_ctrl: key/block handshake sequencer for the Camellia-128 datapath.
// Define CAMELLIA_DEC_EN to enable decryption ordering and FL key swapping.
module camellia_round_ctrl
    import camellia_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       key_load,
    output logic       key_ready,
    output logic       ks_start,
    input  logic       ks_done,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       dec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] step,
    output logic [4:0] ksel,
    output logic       kswap,
    output logic       dp_en,
    output logic       dp_load,
    output logic       busy
);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_rc;
    logic       r_dec;
    logic       r_ks_start;
    logic       w_accept;
    logic       w_dec_in;
    logic [4:0] w_ksel;

`ifdef CAMELLIA_DEC_EN
    assign w_dec_in = dec;
    assign kswap    = r_dec & (r_state == ST_FL);
`else
    logic w_unused_dec;
    assign w_unused_dec = dec;
    assign w_dec_in     = 1'b0;
    assign kswap        = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = key_load ? ST_KEYGEN : ST_IDLE;
            ST_KEYGEN: w_next = ks_done ? ST_READY : ST_KEYGEN;
            ST_READY:  w_next = key_load ? ST_KEYGEN : in_valid ? ST_PRE : ST_READY;
            ST_PRE:    w_next = ST_RND;
            ST_RND:    w_next = (r_rc == 5'd5 || r_rc == 5'd11) ? ST_FL :
                                r_rc == 5'd17 ? ST_POST : ST_RND;
            ST_FL:     w_next = ST_RND;
            ST_POST:   w_next = ST_OUT;
            ST_OUT:    w_next = out_ready ? ST_READY : ST_OUT;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_rc       <= 5'd0;
            r_dec      <= 1'b0;
            r_ks_start <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ks_start <= (w_next == ST_KEYGEN) && (r_state != ST_KEYGEN);
            if (w_accept) begin
                r_rc  <= 5'd0;
                r_dec <= w_dec_in;
            end else if (r_state == ST_FL || (r_state == ST_RND && w_next == ST_RND)) begin
                r_rc <= r_rc + 5'd1;
            end
        end
    end

    assign key_ready = (r_state == ST_IDLE) || (r_state == ST_READY);
    assign in_ready  = (r_state == ST_READY) && !key_load;
    assign w_accept  = in_ready && in_valid;
    assign dp_load   = w_accept;
    assign ks_start  = r_ks_start;
    assign dp_en     = (r_state == ST_PRE) || (r_state == ST_RND) ||
                       (r_state == ST_FL) || (r_state == ST_POST);
    assign busy      = dp_en || (r_state == ST_OUT);
    assign out_valid = r_state == ST_OUT;
    assign step      = r_state == ST_RND  ? STEP_F :
                       r_state == ST_FL   ? STEP_FL :
                       r_state == ST_POST ? STEP_WOUT : STEP_WIN;
    assign ksel      = dp_en ? w_ksel : KSEL_KW1;

    camellia_ksel_rom u_rom (
        .i_step      (step),
        .i_rc        (r_rc),
        .i_dec       (r_dec),
        .i_fl_second (r_rc == 5'd11),
        .o_ksel      (w_ksel)
    );

endmodule

// File: tb/tb_camellia_round_ctrl.sv
// tb_camellia_round_ctrl: directed-vector bench for the Camellia round sequencer.
module tb_camellia_round_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       key_load = 1'b0;
    logic       ks_done = 1'b0;
    logic       in_valid = 1'b0;
    logic       dec = 1'b0;
    logic       out_ready = 1'b0;
    logic       key_ready, ks_start, in_ready, out_valid, kswap, dp_en, dp_load, busy;
    logic [1:0] step;
    logic [4:0] ksel;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [14:0] RESET_VEC = {1'b1, 7'b0, 2'd0, 5'd0};

    logic [4:0] enc_ksel [22] = '{0, 2, 3, 4, 5, 6, 7, 8, 10, 11, 12, 13, 14, 15, 16,
                                  18, 19, 20, 21, 22, 23, 24};
    logic [4:0] dec_ksel [22] = '{24, 23, 22, 21, 20, 19, 18, 16, 15, 14, 13, 12, 11, 10, 8,
                                  7, 6, 5, 4, 3, 2, 0};
    logic [1:0] step_tab [22] = '{0, 1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2,
                                  1, 1, 1, 1, 1, 1, 3};

    always #5 CLK = ~CLK;

    camellia_round_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .key_load  (key_load),
        .key_ready (key_ready),
        .ks_start  (ks_start),
        .ks_done   (ks_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dec       (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .step      (step),
        .ksel      (ksel),
        .kswap     (kswap),
        .dp_en     (dp_en),
        .dp_load   (dp_load),
        .busy      (busy)
    );

    task automatic test_reset();
        logic [14:0] got;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        got = {key_ready, ks_start, in_ready, out_valid, busy, dp_en, dp_load, kswap, step, ksel};
        if (got !== RESET_VEC) begin miscompares++; $display("FAIL reset_held got=%h exp=%h", got, RESET_VEC); end
        vectors++;
        RST = 1'b1;
        @(negedge CLK);
        got = {key_ready, ks_start, in_ready, out_valid, busy, dp_en, dp_load, kswap, step, ksel};
        if (got !== RESET_VEC) begin miscompares++; $display("FAIL reset_idle got=%h exp=%h", got, RESET_VEC); end
        vectors++;
    endtask

    task automatic test_keygen();
        logic [2:0] got;
        key_load = 1'b1;
        #1;
        got = {key_ready, in_ready, ks_start};
        if (got !== 3'b100) begin miscompares++; $display("FAIL keygen_idle got=%b exp=100", got); end
        vectors++;
        @(negedge CLK);
        key_load = 1'b0;
        got = {key_ready, in_ready, ks_start};
        if (got !== 3'b001) begin miscompares++; $display("FAIL keygen_pulse got=%b exp=001", got); end
        vectors++;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            got = {key_ready, in_ready, ks_start};
            if (got !== 3'b000) begin miscompares++; $display("FAIL keygen_wait%0d got=%b exp=000", i, got); end
            vectors++;
        end
        ks_done = 1'b1;
        @(negedge CLK);
        ks_done = 1'b0;
        got = {key_ready, in_ready, ks_start};
        if (got !== 3'b110) begin miscompares++; $display("FAIL keygen_ready got=%b exp=110", got); end
        vectors++;
    endtask

    // starts and ends just after a falling edge with the controller in READY
    task automatic run_block(input logic d, input int hold, input int kl_at, input string nm);
        logic       ed;
        logic [4:0] ek;
        logic [9:0] got10, exp10;
        logic [2:0] got3;
        logic [4:0] got5;
`ifdef CAMELLIA_DEC_EN
        ed = d;
`else
        ed = 1'b0;
`endif
        in_valid = 1'b1;
        dec = d;
        #1;
        got3 = {in_ready, dp_load, busy};
        if (got3 !== 3'b110) begin miscompares++; $display("FAIL %s_accept got=%b exp=110", nm, got3); end
        vectors++;
        for (int j = 0; j < 22; j++) begin
            @(negedge CLK);
            in_valid = 1'b0;
            dec = 1'b0;
            key_load = (j == kl_at);
            ek = ed ? dec_ksel[j] : enc_ksel[j];
            got10 = {step, ksel, kswap, busy, key_ready};
            exp10 = {step_tab[j], ek, ed && step_tab[j] == 2'd2, 1'b1, 1'b0};
            if (got10 !== exp10 || dp_en !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_seq%0d got=%h/%b%b exp=%h/10", nm, j, got10, dp_en, out_valid, exp10);
            end
            vectors++;
        end
        @(negedge CLK);
        key_load = 1'b0;
        got5 = {out_valid, busy, dp_en, in_ready, key_ready};
        if (got5 !== 5'b11000 || ksel !== 5'd0) begin
            miscompares++;
            $display("FAIL %s_out got=%b ksel=%0d exp=11000 ksel=0", nm, got5, ksel);
        end
        vectors++;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            #1;
            got3 = {out_valid, in_ready, dp_load};
            if (got3 !== 3'b100) begin miscompares++; $display("FAIL %s_hold%0d got=%b exp=100", nm, h, got3); end
            vectors++;
            @(negedge CLK);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        got5 = {out_valid, busy, dp_en, in_ready, key_ready};
        if (got5 !== 5'b00011) begin miscompares++; $display("FAIL %s_done got=%b exp=00011", nm, got5); end
        vectors++;
    endtask

    task automatic test_encrypt();
        run_block(1'b0, 0, -1, "enc");
    endtask

    task automatic test_decrypt();
        run_block(1'b1, 0, -1, "dec");
    endtask

    task automatic test_backpressure();
        run_block(1'b0, 10, -1, "bp");
    endtask

    task automatic test_back_to_back();
        run_block(1'b1, 0, 5, "b2b_a");
        run_block(1'b0, 0, 12, "b2b_b");
    endtask

    task automatic test_collision();
        logic [4:0] got;
        key_load = 1'b1;
        in_valid = 1'b1;
        #1;
        got = {in_ready, dp_load, key_ready, busy, ks_start};
        if (got !== 5'b00100) begin miscompares++; $display("FAIL coll_same got=%b exp=00100", got); end
        vectors++;
        @(negedge CLK);
        key_load = 1'b0;
        in_valid = 1'b0;
        got = {in_ready, dp_load, key_ready, busy, ks_start};
        if (got !== 5'b00001 || dp_en !== 1'b0) begin miscompares++; $display("FAIL coll_keygen got=%b dp_en=%b exp=00001", got, dp_en); end
        vectors++;
        ks_done = 1'b1;
        @(negedge CLK);
        ks_done = 1'b0;
        got = {in_ready, dp_load, key_ready, busy, ks_start};
        if (got !== 5'b10100) begin miscompares++; $display("FAIL coll_ready got=%b exp=10100", got); end
        vectors++;
    endtask

    task automatic test_rst_mid();
        logic [14:0] got;
        logic [1:0]  got2;
        in_valid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge CLK);
            in_valid = 1'b0;
        end
        if (busy !== 1'b1 || step !== 2'd1) begin miscompares++; $display("FAIL rst_pre busy=%b step=%0d exp busy=1 step=1", busy, step); end
        vectors++;
        RST = 1'b0;
        #1;
        got = {key_ready, ks_start, in_ready, out_valid, busy, dp_en, dp_load, kswap, step, ksel};
        if (got !== RESET_VEC) begin miscompares++; $display("FAIL rst_async got=%h exp=%h", got, RESET_VEC); end
        vectors++;
        @(negedge CLK);
        RST = 1'b1;
        in_valid = 1'b1;
        #1;
        got2 = {in_ready, dp_load};
        if (got2 !== 2'b00) begin miscompares++; $display("FAIL rst_noaccept got=%b exp=00", got2); end
        vectors++;
        @(negedge CLK);
        in_valid = 1'b0;
        got = {key_ready, ks_start, in_ready, out_valid, busy, dp_en, dp_load, kswap, step, ksel};
        if (got !== RESET_VEC) begin miscompares++; $display("FAIL rst_idle got=%h exp=%h", got, RESET_VEC); end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_keygen();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_back_to_back();
        test_collision();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
